dma_mem_responder: RTL and testbench

//   Responder end of the DMA master's simple request bus (R_req/AR_ADDR/R_DATA/R_valid,
//   W_req/AW_ADDR/W_DATA/W_done). Serves one transaction at a time against a single-port

---
 rtl/dma_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_dma_mem_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dma_mem_responder
// Brief   : Single-outstanding DMA request-bus responder in front of a 1-cycle
//           synchronous SRAM, with wait states, range checking and error record.
// Revision: 1.0 - initial release
// ============================================================================
module dma_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_W      = 14,
    parameter int          WAIT_CYCLES = 0,
    parameter int          TURN_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              R_req,
    input  logic [31:0]       AR_ADDR,
    output logic [31:0]       R_DATA,
    output logic              R_valid,
    input  logic              W_req,
    input  logic [31:0]       AW_ADDR,
    input  logic [31:0]       W_DATA,
    output logic              W_done,
    output logic              mem_CEB,
    output logic              mem_WEB,
    output logic [ADDR_W-1:0] mem_A,
    output logic [31:0]       mem_DI,
    input  logic [31:0]       mem_DO,
    output logic              err_flag,
    output logic [31:0]       err_addr,
    input  logic              err_clr
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_wait   = 3'd1;
    localparam logic [2:0] c_st_access = 3'd2;
    localparam logic [2:0] c_st_resp   = 3'd3;
    localparam logic [2:0] c_st_turn   = 3'd4;

    localparam logic [7:0]  c_wait_load = 8'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
    localparam logic [7:0]  c_turn_load = 8'(TURN_CYCLES > 0 ? TURN_CYCLES - 1 : 0);
    localparam logic [32:0] c_window    = 33'(64'd4 << ADDR_W);

    logic [2:0]        state_q,    state_d;
    logic [7:0]        cnt_q,      cnt_d;
    logic              op_wr_q,    op_wr_d;
    logic              bad_q,      bad_d;
    logic [31:0]       addr_q,     addr_d;
    logic [ADDR_W-1:0] word_q,     word_d;
    logic [31:0]       data_q,     data_d;
    logic              err_flag_q, err_flag_d;
    logic [31:0]       err_addr_q, err_addr_d;

    logic [31:0] w_req_addr;
    logic [31:0] w_offset;
    logic        w_bad;

    assign w_req_addr = W_req ? AW_ADDR : AR_ADDR;
    // Offset wraps for addresses below the base, landing out of range.
    assign w_offset   = w_req_addr - BASE_ADDR;
    assign w_bad      = ({1'b0, w_offset} >= c_window) || (w_req_addr[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        bad_d      = bad_q;
        addr_d     = addr_q;
        word_d     = word_q;
        data_d     = data_q;
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;

        if (err_clr) begin
            err_flag_d = 1'b0;
            err_addr_d = 32'h0;
        end

        case (state_q)
            c_st_idle: begin
                if (W_req || R_req) begin
                    op_wr_d = W_req;
                    addr_d  = w_req_addr;
                    bad_d   = w_bad;
                    word_d  = w_offset[ADDR_W+1:2];
                    if (W_req) begin
                        data_d = W_DATA;
                    end
                    if (WAIT_CYCLES > 0) begin
                        state_d = c_st_wait;
                        cnt_d   = c_wait_load;
                    end else begin
                        state_d = c_st_access;
                    end
                end
            end
            c_st_wait: begin
                if (cnt_q == 8'd0) begin
                    state_d = c_st_access;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            c_st_access: begin
                state_d = c_st_resp;
            end
            c_st_resp: begin
                state_d = c_st_turn;
                cnt_d   = c_turn_load;
                // A new error outranks a simultaneous clear.
                if (bad_q && !err_flag_d) begin
                    err_flag_d = 1'b1;
                    err_addr_d = addr_q;
                end
            end
            c_st_turn: begin
                if (cnt_q == 8'd0) begin
                    state_d = c_st_idle;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= c_st_idle;
            cnt_q      <= 8'd0;
            op_wr_q    <= 1'b0;
            bad_q      <= 1'b0;
            addr_q     <= 32'h0;
            word_q     <= '0;
            data_q     <= 32'h0;
            err_flag_q <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_wr_q    <= op_wr_d;
            bad_q      <= bad_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            data_q     <= data_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign mem_CEB  = !((state_q == c_st_access) && !bad_q);
    assign mem_WEB  = !((state_q == c_st_access) && !bad_q && op_wr_q);
    assign mem_A    = word_q;
    assign mem_DI   = data_q;
    assign R_valid  = (state_q == c_st_resp) && !op_wr_q;
    assign W_done   = (state_q == c_st_resp) && op_wr_q;
    assign R_DATA   = (R_valid && !bad_q) ? mem_DO : 32'h0;
    assign err_flag = err_flag_q;
    assign err_addr = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dma_mem_responder
// Brief   : Self-checking bench: directed vector table, hand-written corner
//           sequences and randomized traffic against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dma_mem_responder;

    localparam logic [31:0] c_base = 32'h1000_0000;
    localparam int          c_aw   = 8;
    localparam int          c_turn = 1;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [1:0]  r_req, w_req, r_valid, w_done, mem_ceb, mem_web, err_flag, err_clr;
    logic [31:0] ar_addr, aw_addr, w_data;
    logic [31:0] r_data [2];
    logic [31:0] mem_di [2];
    logic [31:0] err_addr [2];
    logic [c_aw-1:0] mem_a [2];
    logic [31:0] mem_do0, mem_do1;
    logic [31:0] sram0 [256];
    logic [31:0] sram1 [256];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dma_mem_responder #(.BASE_ADDR(c_base), .ADDR_W(c_aw), .WAIT_CYCLES(0), .TURN_CYCLES(c_turn)) dut_a (
        .clk(clk), .rst(rst_a), .R_req(r_req[0]), .AR_ADDR(ar_addr), .R_DATA(r_data[0]),
        .R_valid(r_valid[0]), .W_req(w_req[0]), .AW_ADDR(aw_addr), .W_DATA(w_data),
        .W_done(w_done[0]), .mem_CEB(mem_ceb[0]), .mem_WEB(mem_web[0]), .mem_A(mem_a[0]),
        .mem_DI(mem_di[0]), .mem_DO(mem_do0), .err_flag(err_flag[0]), .err_addr(err_addr[0]),
        .err_clr(err_clr[0]));

    dma_mem_responder #(.BASE_ADDR(c_base), .ADDR_W(c_aw), .WAIT_CYCLES(3), .TURN_CYCLES(c_turn)) dut_b (
        .clk(clk), .rst(rst_b), .R_req(r_req[1]), .AR_ADDR(ar_addr), .R_DATA(r_data[1]),
        .R_valid(r_valid[1]), .W_req(w_req[1]), .AW_ADDR(aw_addr), .W_DATA(w_data),
        .W_done(w_done[1]), .mem_CEB(mem_ceb[1]), .mem_WEB(mem_web[1]), .mem_A(mem_a[1]),
        .mem_DI(mem_di[1]), .mem_DO(mem_do1), .err_flag(err_flag[1]), .err_addr(err_addr[1]),
        .err_clr(err_clr[1]));

    // Behavioural single-port SRAMs, one per responder.
    always @(posedge clk) begin
        if (!mem_ceb[0]) begin
            if (!mem_web[0]) sram0[mem_a[0]] <= mem_di[0];
            else             mem_do0 <= sram0[mem_a[0]];
        end
    end
    always @(posedge clk) begin
        if (!mem_ceb[1]) begin
            if (!mem_web[1]) sram1[mem_a[1]] <= mem_di[1];
            else             mem_do1 <= sram1[mem_a[1]];
        end
    end

    // Transaction-level reference for dut_a.
    logic [31:0] ref_mem [256];
    bit          ref_ok  [256];
    bit          ex_flag;
    logic [31:0] ex_eaddr;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        bit          exp_flag;
        logic [31:0] exp_eaddr;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - c_base;
        return (off >= 32'd1024) || (a % 4 != 0);
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        return int'((a - c_base) / 4);
    endfunction

    task automatic model_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] exp_rd);
        exp_rd = 32'h0;
        if (is_bad(a)) begin
            if (!ex_flag) begin
                ex_flag  = 1'b1;
                ex_eaddr = a;
            end
        end else if (wr) begin
            ref_mem[word_idx(a)] = d;
            ref_ok[word_idx(a)]  = 1'b1;
        end else begin
            exp_rd = ref_mem[word_idx(a)];
        end
    endtask

    // Called just after a falling edge with the responder idle.
    task automatic do_txn(input int s, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat, output int ceb_lows);
        bit ok;
        ok = 1'b0; rd = 32'h0; lat = 0; ceb_lows = 0;
        if (wr) begin aw_addr = a; w_data = d; w_req[s] = 1'b1; end
        else    begin ar_addr = a; r_req[s] = 1'b1; end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (!mem_ceb[s]) ceb_lows++;
            if (wr ? w_done[s] : r_valid[s]) begin
                ok = 1'b1;
                rd = r_data[s];
                break;
            end
        end
        chk("txn_response_seen", 32'(ok), 32'd1);
        r_req[s] = 1'b0;
        w_req[s] = 1'b0;
        @(negedge clk);
        chk("txn_single_pulse", 32'(wr ? w_done[s] : r_valid[s]), 32'd0);
        repeat (c_turn + 1) @(negedge clk);
    endtask

    task automatic run_checked(input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] exp_rd, rd;
        int lat, lows;
        model_txn(wr, a, d, exp_rd);
        do_txn(0, wr, a, d, rd, lat, lows);
        if (!wr) chk("rand_rdata", rd, exp_rd);
        chk("rand_latency", 32'(lat), 32'd2);
        chk("rand_ceb_cycles", 32'(lows), is_bad(a) ? 32'd0 : 32'd1);
        chk("rand_err_flag", 32'(err_flag[0]), 32'(ex_flag));
        chk("rand_err_addr", err_addr[0], ex_eaddr);
    endtask

    initial begin
        logic [31:0] rd, a, exp_rd;
        int lat, lows, gap, pulses;
        bit got;

        tbl[0] = '{1'b1, c_base + 32'h14,  32'hCAFE_0005, 32'h0,          1'b0, 32'h0};
        tbl[1] = '{1'b0, c_base + 32'h14,  32'h0,         32'hCAFE_0005, 1'b0, 32'h0};
        tbl[2] = '{1'b1, c_base + 32'h40,  32'h1234_5678, 32'h0,          1'b0, 32'h0};
        tbl[3] = '{1'b0, c_base + 32'h40,  32'h0,         32'h1234_5678, 1'b0, 32'h0};
        tbl[4] = '{1'b0, c_base + 32'h400, 32'h0,         32'h0,          1'b1, c_base + 32'h400};
        tbl[5] = '{1'b1, c_base + 32'h2,   32'hDEAD_BEEF, 32'h0,          1'b1, c_base + 32'h400};
        tbl[6] = '{1'b1, c_base + 32'h3FC, 32'hA5A5_0FFF, 32'h0,          1'b1, c_base + 32'h400};
        tbl[7] = '{1'b0, c_base + 32'h3FC, 32'h0,         32'hA5A5_0FFF, 1'b1, c_base + 32'h400};
        tbl[8] = '{1'b0, c_base + 32'h14,  32'h0,         32'hCAFE_0005, 1'b1, c_base + 32'h400};
        tbl[9] = '{1'b0, c_base - 32'h4,   32'h0,         32'h0,          1'b1, c_base + 32'h400};

        ex_flag = 1'b0; ex_eaddr = 32'h0;
        for (int i = 0; i < 256; i++) ref_ok[i] = 1'b0;
        r_req = '0; w_req = '0; err_clr = '0;
        ar_addr = '0; aw_addr = '0; w_data = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_r_valid",  32'(r_valid[0]),  32'd0);
        chk("rst_w_done",   32'(w_done[0]),   32'd0);
        chk("rst_ceb",      32'(mem_ceb[0]),  32'd1);
        chk("rst_web",      32'(mem_web[0]),  32'd1);
        chk("rst_mem_a",    32'(mem_a[0]),    32'd0);
        chk("rst_mem_di",   mem_di[0],        32'h0);
        chk("rst_r_data",   r_data[0],        32'h0);
        chk("rst_err_flag", 32'(err_flag[0]), 32'd0);
        chk("rst_err_addr", err_addr[0],      32'h0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            do_txn(0, tbl[i].wr, tbl[i].addr, tbl[i].data, rd, lat, lows);
            model_txn(tbl[i].wr, tbl[i].addr, tbl[i].data, exp_rd);
            if (!tbl[i].wr) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("tbl%0d_ceb_cycles", i), 32'(lows), is_bad(tbl[i].addr) ? 32'd0 : 32'd1);
            chk($sformatf("tbl%0d_err_flag", i), 32'(err_flag[0]), 32'(tbl[i].exp_flag));
            chk($sformatf("tbl%0d_err_addr", i), err_addr[0], tbl[i].exp_eaddr);
        end

        // Error clear.
        err_clr[0] = 1'b1;
        @(negedge clk);
        err_clr[0] = 1'b0;
        ex_flag = 1'b0; ex_eaddr = 32'h0;
        chk("clr_err_flag", 32'(err_flag[0]), 32'd0);
        chk("clr_err_addr", err_addr[0], 32'h0);

        // Descriptor burst with req held and address advanced one edge after each pulse.
        for (int k = 0; k < 5; k++) run_checked(1'b1, c_base + 32'h80 + 32'(4 * k), 32'hD000_0000 + 32'(k));
        ar_addr = c_base + 32'h80;
        r_req[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            got = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (r_valid[0]) begin got = 1'b1; break; end
            end
            chk($sformatf("burst%0d_seen", k), 32'(got), 32'd1);
            chk($sformatf("burst%0d_rdata", k), r_data[0], 32'hD000_0000 + 32'(k));
            @(posedge clk);
            @(posedge clk);
            #1;
            ar_addr = c_base + 32'h80 + 32'(4 * (k + 1));
            if (k == 4) r_req[0] = 1'b0;
        end
        pulses = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (r_valid[0]) pulses++;
        end
        chk("burst_no_extra_pulse", 32'(pulses), 32'd0);

        // Simultaneous write and read: write first, read after turnaround.
        aw_addr = c_base + 32'h100; w_data = 32'h7777_0100; ar_addr = c_base + 32'h14;
        w_req[0] = 1'b1; r_req[0] = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (w_done[0] || r_valid[0]) break;
        end
        chk("simul_first_is_write", 32'(w_done[0]), 32'd1);
        chk("simul_no_early_read", 32'(r_valid[0]), 32'd0);
        w_req[0] = 1'b0;
        model_txn(1'b1, c_base + 32'h100, 32'h7777_0100, exp_rd);
        model_txn(1'b0, c_base + 32'h14, 32'h0, exp_rd);
        gap = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); gap++;
            @(negedge clk);
            if (r_valid[0]) break;
        end
        chk("simul_read_gap", 32'(gap), 32'(3 + c_turn));
        chk("simul_rdata", r_data[0], exp_rd);
        r_req[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            int sel, idx;
            bit wr;
            sel = int'($urandom_range(0, 9));
            idx = int'($urandom_range(0, 255));
            wr  = 1'($urandom_range(0, 1));
            case (sel)
                0:       a = c_base + 32'(4 * idx) + 32'($urandom_range(1, 3));
                1:       a = c_base + 32'h400 + 32'(4 * $urandom_range(0, 100));
                2:       a = c_base - 32'(4 * $urandom_range(1, 16));
                default: a = c_base + 32'(4 * idx);
            endcase
            if (!wr && !is_bad(a) && !ref_ok[word_idx(a)]) wr = 1'b1;
            run_checked(wr, a, $urandom);
            if ($urandom_range(0, 7) == 0) begin
                err_clr[0] = 1'b1;
                @(negedge clk);
                err_clr[0] = 1'b0;
                ex_flag = 1'b0; ex_eaddr = 32'h0;
                chk("rand_clr_flag", 32'(err_flag[0]), 32'd0);
            end
        end

        // Wait states on the second responder.
        do_txn(1, 1'b1, c_base + 32'h40, 32'h1234_5678, rd, lat, lows);
        chk("wait3_write_latency", 32'(lat), 32'd5);
        chk("wait3_write_ceb", 32'(lows), 32'd1);
        do_txn(1, 1'b0, c_base + 32'h40, 32'h0, rd, lat, lows);
        chk("wait3_read_latency", 32'(lat), 32'd5);
        chk("wait3_readback", rd, 32'h1234_5678);

        // Reset while a write sits in its wait states.
        aw_addr = c_base + 32'h40; w_data = 32'hFFFF_0000; w_req[1] = 1'b1;
        @(posedge clk);
        #2 rst_b = 1'b1;
        lows = 0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (!mem_ceb[1]) lows++;
        end
        chk("rstmid_ceb_never_low", 32'(lows), 32'd0);
        chk("rstmid_w_done", 32'(w_done[1]), 32'd0);
        chk("rstmid_web", 32'(mem_web[1]), 32'd1);
        chk("rstmid_mem_a", 32'(mem_a[1]), 32'd0);
        chk("rstmid_mem_di", mem_di[1], 32'h0);
        w_req[1] = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        do_txn(1, 1'b0, c_base + 32'h40, 32'h0, rd, lat, lows);
        chk("rstmid_sram_kept", rd, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
